// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph constants and segment type for the digit display path.
// Bit order is {a,b,c,d,e,f,g}, logical 1 = lit.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'b1111110;
  localparam seg_t SEG_1    = 7'b0110000;
  localparam seg_t SEG_2    = 7'b1101101;
  localparam seg_t SEG_3    = 7'b1111001;
  localparam seg_t SEG_4    = 7'b0110011;
  localparam seg_t SEG_5    = 7'b1011011;
  localparam seg_t SEG_6    = 7'b1011111;
  localparam seg_t SEG_7    = 7'b1110000;
  localparam seg_t SEG_8    = 7'b1111111;
  localparam seg_t SEG_9    = 7'b1111011;
  localparam seg_t SEG_A    = 7'b1110111;
  localparam seg_t SEG_B    = 7'b0011111;
  localparam seg_t SEG_C    = 7'b1001110;
  localparam seg_t SEG_D    = 7'b0111101;
  localparam seg_t SEG_E    = 7'b1001111;
  localparam seg_t SEG_F    = 7'b1000111;
  localparam seg_t SEG_DASH = 7'b0000001;
  localparam seg_t SEG_ALL  = 7'b1111111;
  localparam seg_t SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational code-to-glyph lookup; codes 10-15 decode to letters only in hex mode,
// otherwise they show a dash and report invalid.
module bcd_seg_lut
  import seg7_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  logic [3:0] code,
  output seg_t       glyph,
  output logic       valid
);

  always_comb begin
    glyph = SEG_DASH;
    valid = HEX_MODE || (code <= 4'd9);
    case (code)
      4'd0:  glyph = SEG_0;
      4'd1:  glyph = SEG_1;
      4'd2:  glyph = SEG_2;
      4'd3:  glyph = SEG_3;
      4'd4:  glyph = SEG_4;
      4'd5:  glyph = SEG_5;
      4'd6:  glyph = SEG_6;
      4'd7:  glyph = SEG_7;
      4'd8:  glyph = SEG_8;
      4'd9:  glyph = SEG_9;
      4'd10: glyph = HEX_MODE ? SEG_A : SEG_DASH;
      4'd11: glyph = HEX_MODE ? SEG_B : SEG_DASH;
      4'd12: glyph = HEX_MODE ? SEG_C : SEG_DASH;
      4'd13: glyph = HEX_MODE ? SEG_D : SEG_DASH;
      4'd14: glyph = HEX_MODE ? SEG_E : SEG_DASH;
      default: glyph = HEX_MODE ? SEG_F : SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_to_7seg.sv
// Registered single-digit BCD/hex to seven-segment driver with lamp test, blanking,
// ripple-blank zero suppression and a saturating invalid-load counter.
module bcd_to_7seg
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_MODE   = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       bcd,
  input  logic             load,
  input  logic             blank,
  input  logic             lamp_test,
  input  logic             rbi,
  output logic [6:0]       seg,
  output logic             valid,
  output logic             rbo,
  output logic [CNT_W-1:0] err_count
);

  localparam seg_t SEG_RST = ACTIVE_LOW ? SEG_ALL : SEG_OFF;

  logic [3:0] digit_q, digit_d;
  seg_t       glyph, seg_lgc;
  logic       code_ok, is_zero, rbo_d;

  // Outputs are computed from the value the digit register is about to hold.
  assign digit_d = load ? bcd : digit_q;
  assign is_zero = (digit_d == 4'd0);

  bcd_seg_lut #(.HEX_MODE(HEX_MODE)) u_lut (
    .code  (digit_d),
    .glyph (glyph),
    .valid (code_ok)
  );

  always_comb begin
    seg_lgc = glyph;
    if (lamp_test)            seg_lgc = SEG_ALL;
    else if (blank)           seg_lgc = SEG_OFF;
    else if (rbi && is_zero)  seg_lgc = SEG_OFF;
  end

  assign rbo_d = rbi && is_zero && !lamp_test && !blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q   <= 4'd0;
      seg       <= SEG_RST;
      valid     <= 1'b0;
      rbo       <= 1'b0;
      err_count <= '0;
    end else begin
      digit_q <= digit_d;
      seg     <= ACTIVE_LOW ? ~seg_lgc : seg_lgc;
      valid   <= code_ok;
      rbo     <= rbo_d;
      if (load && !code_ok && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_bcd_to_7seg.sv
// Bench for bcd_to_7seg: a default instance and a hex/active-low instance share stimulus;
// directed vector table plus randomized traffic against a reference model.
module tb_bcd_to_7seg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       load = 1'b0, blank = 1'b0, lamp_test = 1'b0, rbi = 1'b0;
  logic [6:0] seg0, seg1;
  logic       valid0, valid1, rbo0, rbo1;
  logic [7:0] err0, err1;

  always #5 clk = ~clk;

  bcd_to_7seg u_dut0 (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .blank(blank),
    .lamp_test(lamp_test), .rbi(rbi), .seg(seg0), .valid(valid0), .rbo(rbo0),
    .err_count(err0)
  );

  bcd_to_7seg #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .blank(blank),
    .lamp_test(lamp_test), .rbi(rbi), .seg(seg1), .valid(valid1), .rbo(rbo1),
    .err_count(err1)
  );

  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int n_chk = 0, n_fail = 0;

  // Reference model: held code and per-instance error counts (instance 1 = hex, active-low)
  int         m_code = 0;
  int         m_err [2] = '{0, 0};
  logic [6:0] e_seg [2];
  logic       e_vld [2], e_rbo [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_code = 0;
    m_err[0] = 0;
    m_err[1] = 0;
  endtask

  // One clock with the currently driven inputs; compares both instances to the model.
  task automatic tick();
    int  c;
    bit  ok, hex, al;
    logic [6:0] lg;
    c = load ? int'(bcd) : m_code;
    for (int i = 0; i < 2; i++) begin
      hex = (i == 1);
      al  = (i == 1);
      ok  = hex || (c <= 9);
      if (load && !ok && m_err[i] < 255) m_err[i]++;
      if (lamp_test)             lg = 7'h7f;
      else if (blank)            lg = 7'h00;
      else if (rbi && c == 0)    lg = 7'h00;
      else if (ok)               lg = GLYPH[c];
      else                       lg = 7'b0000001;
      e_seg[i] = al ? ~lg : lg;
      e_vld[i] = ok;
      e_rbo[i] = rbi && (c == 0) && !lamp_test && !blank;
    end
    m_code = c;
    @(posedge clk);
    #1;
    check("m0_seg", 32'(seg0), 32'(e_seg[0]));
    check("m0_valid", 32'(valid0), 32'(e_vld[0]));
    check("m0_rbo", 32'(rbo0), 32'(e_rbo[0]));
    check("m0_err", 32'(err0), 32'(m_err[0]));
    check("m1_seg", 32'(seg1), 32'(e_seg[1]));
    check("m1_valid", 32'(valid1), 32'(e_vld[1]));
    check("m1_rbo", 32'(rbo1), 32'(e_rbo[1]));
    check("m1_err", 32'(err1), 32'(m_err[1]));
  endtask

  task automatic drive(input logic ld, input logic [3:0] code, input logic blk,
                       input logic lt, input logic rb);
    load = ld; bcd = code; blank = blk; lamp_test = lt; rbi = rb;
  endtask

  task automatic mid_cycle_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_seg0", 32'(seg0), 32'h00);
    check("rst_seg1", 32'(seg1), 32'h7f);
    check("rst_valid0", 32'(valid0), 32'd0);
    check("rst_rbo0", 32'(rbo0), 32'd0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_err1", 32'(err1), 32'd0);
    model_reset();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] code;
    logic       blk, lt, rb;
    logic [6:0] seg;
    logic       vld, rbo;
    logic [7:0] err;
  } vec_t;

  vec_t tv[$];

  initial begin
    // Directed expectations for the default instance, written from the glyph list.
    tv.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 7'b1111110, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 7'b1111110, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 7'b0110000, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 7'b1101101, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 7'b1111001, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 7'b0110011, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 7'b1011011, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd6,  1'b0, 1'b0, 1'b0, 7'b1011111, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 7'b1110000, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 7'b1111111, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 7'b1111011, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 7'b1111011, 1'b1, 1'b0, 8'd0});
    tv.push_back('{1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0, 1'b0, 8'd1});
    tv.push_back('{1'b1, 4'd11, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0, 1'b0, 8'd2});
    tv.push_back('{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0, 1'b0, 8'd3});
    tv.push_back('{1'b1, 4'd13, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0, 1'b0, 8'd4});
    tv.push_back('{1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0, 1'b0, 8'd5});
    tv.push_back('{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 7'b0000001, 1'b0, 1'b0, 8'd6});
    tv.push_back('{1'b1, 4'd5,  1'b1, 1'b1, 1'b0, 7'b1111111, 1'b1, 1'b0, 8'd6});
    tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 1'b0, 8'd6});
    tv.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 7'b1011011, 1'b1, 1'b0, 8'd6});
    tv.push_back('{1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 7'b0000000, 1'b1, 1'b1, 8'd6});
    tv.push_back('{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 7'b0000000, 1'b1, 1'b0, 8'd6});
    tv.push_back('{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 7'b1111111, 1'b1, 1'b0, 8'd6});
    tv.push_back('{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 7'b1111110, 1'b1, 1'b0, 8'd6});
    tv.push_back('{1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 7'b1111001, 1'b1, 1'b0, 8'd6});

    // Reset held from time zero
    #12;
    check("init_seg0", 32'(seg0), 32'h00);
    check("init_seg1", 32'(seg1), 32'h7f);
    check("init_valid1", 32'(valid1), 32'd0);
    check("init_err0", 32'(err0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
    tick();
    mid_cycle_reset();

    foreach (tv[i]) begin
      drive(tv[i].ld, tv[i].code, tv[i].blk, tv[i].lt, tv[i].rb);
      tick();
      check($sformatf("vec%0d_seg", i), 32'(seg0), 32'(tv[i].seg));
      check($sformatf("vec%0d_valid", i), 32'(valid0), 32'(tv[i].vld));
      check($sformatf("vec%0d_rbo", i), 32'(rbo0), 32'(tv[i].rbo));
      check($sformatf("vec%0d_err", i), 32'(err0), 32'(tv[i].err));
    end

    // Saturation: 300 back-to-back invalid loads
    drive(1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) tick();
    check("sat_err0", 32'(err0), 32'd255);
    drive(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
    tick();
    check("sat_hold_err0", 32'(err0), 32'd255);

    // Hex, active-low instance shows C inverted with no error
    drive(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    tick();
    check("hex_seg1", 32'(seg1), 32'b0110001);
    check("hex_valid1", 32'(valid1), 32'd1);
    check("hex_err1", 32'(err1), 32'd0);
    check("hex_valid0", 32'(valid0), 32'd0);

    // Randomized traffic from a fresh reset
    mid_cycle_reset();
    for (int k = 0; k < 500; k++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
